// File: rtl/tdm_pcm_tx_if.sv
// Frame handshake between the PCM producer and the TDM transmitter.
// One 16-channel frame of signed PCM words is transferred per in_valid && in_ready.
interface tdm_pcm_tx_if #(
    parameter int N_CH   = 16,
    parameter int DATA_W = 19
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N_CH*DATA_W-1:0] pcm_flat;

    modport master (output in_valid, output pcm_flat, input in_ready);
    modport slave  (input in_valid, input pcm_flat, output in_ready);
endinterface

// File: rtl/tdm_pcm_tx.sv
// TDM PCM transmitter: double-buffered frame capture, bit clock generation and
// MSB-first slot serialization. Serial bits are muxed from the active frame.
//
// state | meaning
// IDLE  | link quiet (bclk/fs/sd low), waiting for the first frame
// RUN   | bclk running, frames streamed back to back (zeros on underrun)
module tdm_pcm_tx #(
    parameter int N_CH      = 16,
    parameter int DATA_W    = 19,
    parameter int SLOT_BITS = 24,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst,
    tdm_pcm_tx_if.slave pcm,
    output logic        tdm_bclk,
    output logic        tdm_fs,
    output logic        tdm_sd,
    output logic        underrun,
    output logic        overrun
);
    localparam int SLOT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BIT_W  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef logic [DATA_W-1:0] word_t;

    state_t            state;
    word_t             hold_buf [N_CH];
    word_t             active   [N_CH];
    word_t             incoming [N_CH];
    logic              hold_full;
    logic [SLOT_W-1:0] slot_idx;
    logic [BIT_W-1:0]  bit_idx;
    logic [DIV_W-1:0]  div_cnt;

    logic              fall_edge;
    logic              frame_end;
    logic              load_now;
    logic              accept;
    logic [SLOT_W-1:0] nxt_slot;
    logic [BIT_W-1:0]  nxt_bit;

    // Bits past DATA_W inside a slot are padding and always transmit as 0.
    function automatic logic pick_bit(input word_t w, input logic [BIT_W-1:0] b);
        word_t sh;
        sh = w << b;
        return (int'(b) < DATA_W) ? sh[DATA_W-1] : 1'b0;
    endfunction

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            incoming[k] = pcm.pcm_flat[k*DATA_W +: DATA_W];
        end
    end

    assign fall_edge    = (state == RUN) && (div_cnt == DIV_LAST) && tdm_bclk;
    assign frame_end    = (slot_idx == LAST_SLOT) && (bit_idx == LAST_BIT);
    assign load_now     = hold_full && ((state == IDLE) || (fall_edge && frame_end));
    assign pcm.in_ready = !hold_full || load_now;
    assign accept       = pcm.in_valid && pcm.in_ready;

    always_comb begin
        nxt_slot = slot_idx;
        nxt_bit  = bit_idx + BIT_W'(1);
        if (bit_idx == LAST_BIT) begin
            nxt_bit  = '0;
            nxt_slot = (slot_idx == LAST_SLOT) ? '0 : slot_idx + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            slot_idx  <= '0;
            bit_idx   <= '0;
            div_cnt   <= '0;
            tdm_bclk  <= 1'b0;
            tdm_fs    <= 1'b0;
            tdm_sd    <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                hold_buf[k] <= '0;
                active[k]   <= '0;
            end
        end else begin
            underrun <= 1'b0;
            overrun  <= pcm.in_valid && !pcm.in_ready;

            // A capture in the same cycle as a transfer keeps the hold full.
            if (accept) begin
                hold_buf  <= incoming;
                hold_full <= 1'b1;
            end else if (load_now) begin
                hold_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        state    <= RUN;
                        active   <= hold_buf;
                        slot_idx <= '0;
                        bit_idx  <= '0;
                        div_cnt  <= '0;
                        tdm_bclk <= 1'b0;
                        tdm_fs   <= 1'b1;
                        tdm_sd   <= pick_bit(hold_buf[0], '0);
                    end
                end
                RUN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        tdm_bclk <= !tdm_bclk;
                        if (tdm_bclk) begin
                            slot_idx <= nxt_slot;
                            bit_idx  <= nxt_bit;
                            tdm_fs   <= frame_end;
                            if (!frame_end) begin
                                tdm_sd <= pick_bit(active[nxt_slot], nxt_bit);
                            end else if (hold_full) begin
                                active <= hold_buf;
                                tdm_sd <= pick_bit(hold_buf[0], '0);
                            end else begin
                                active   <= '{default: '0};
                                tdm_sd   <= 1'b0;
                                underrun <= 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdm_pcm_tx.sv
// Scoreboard bench for tdm_pcm_tx: accepted frames are expanded into expected
// serial streams and compared against frames reassembled from the TDM link.
module tb_tdm_pcm_tx;
    localparam int N_CH      = 16;
    localparam int DATA_W    = 19;
    localparam int SLOT_BITS = 24;
    localparam int CLK_DIV   = 4;
    localparam int NB        = N_CH * SLOT_BITS;
    localparam int FRAME_CYC = 2 * CLK_DIV * NB;

    typedef logic [N_CH*DATA_W-1:0] pcm_t;
    typedef logic [NB-1:0]          ser_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tdm_bclk, tdm_fs, tdm_sd, underrun, overrun;

    tdm_pcm_tx_if #(.N_CH(N_CH), .DATA_W(DATA_W)) pif ();

    tdm_pcm_tx #(.N_CH(N_CH), .DATA_W(DATA_W), .SLOT_BITS(SLOT_BITS), .CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .pcm      (pif),
        .tdm_bclk (tdm_bclk),
        .tdm_fs   (tdm_fs),
        .tdm_sd   (tdm_sd),
        .underrun (underrun),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ser_t exp_q[$];
    ser_t rx_q[$];
    int   fs_q[$];
    int   under_cnt, over_cnt, under_first, rise_cnt, rise_last, rise_prev;
    int   pos = -1;
    logic prev_bclk, prev_fs;
    ser_t rx_cur;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each slot is the word MSB first followed by zero padding.
    function automatic ser_t expand(input pcm_t p);
        ser_t e = '0;
        for (int k = 0; k < N_CH; k++) begin
            e = (e << SLOT_BITS) | ser_t'({p[k*DATA_W +: DATA_W], {(SLOT_BITS-DATA_W){1'b0}}});
        end
        return e;
    endfunction

    function automatic pcm_t ramp_frame(input int base);
        pcm_t p;
        for (int k = 0; k < N_CH; k++) p[k*DATA_W +: DATA_W] = DATA_W'(base + k);
        return p;
    endfunction

    function automatic pcm_t rand_frame();
        pcm_t p;
        for (int k = 0; k < N_CH; k++) p[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        return p;
    endfunction

    // Receiver: samples on bclk rising edges, aligns on fs, rebuilds frames.
    always @(negedge clk) begin
        if (rst) begin
            pos = -1;
            prev_bclk = 1'b0;
            prev_fs = 1'b0;
        end else begin
            if (underrun) begin
                if (under_cnt == 0) under_first = cyc;
                under_cnt++;
            end
            if (overrun) over_cnt++;
            if (tdm_fs && !prev_fs) fs_q.push_back(cyc);
            if (tdm_bclk && !prev_bclk) begin
                rise_cnt++;
                rise_prev = rise_last;
                rise_last = cyc;
                if (tdm_fs) begin
                    if (pos != -1) begin
                        checks++;
                        if (pos != NB) begin
                            errors++;
                            $display("FAIL fs_align: fs seen at bit %0d, required at bit %0d", pos, NB);
                        end
                    end
                    pos = 0;
                end else if (pos == NB) begin
                    checks++;
                    errors++;
                    $display("FAIL fs_missing: fs low at frame boundary, required high");
                    pos = -1;
                end
                if (pos >= 0 && pos < NB) begin
                    rx_cur[NB-1-pos] = tdm_sd;
                    pos++;
                    if (pos == NB) rx_q.push_back(rx_cur);
                end
            end
            prev_bclk = tdm_bclk;
            prev_fs = tdm_fs;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        pif.in_valid = 1'b0;
        pif.pcm_flat = '0;
        repeat (3) @(negedge clk);
        exp_q.delete(); rx_q.delete(); fs_q.delete();
        under_cnt = 0; over_cnt = 0; rise_cnt = 0; rise_last = 0; rise_prev = 0;
        #3 rst = 1'b0;
        @(negedge clk);
    endtask

    // Offers a frame until accepted; on acceptance the expected stream is queued.
    task automatic send_frame(input pcm_t p, output logic ok);
        int n = 0;
        pif.in_valid = 1'b1;
        pif.pcm_flat = p;
        while (!pif.in_ready && n < FRAME_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        ok = pif.in_ready;
        if (ok) exp_q.push_back(expand(p));
        @(negedge clk);
        pif.in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, output logic got);
        int budget = n * FRAME_CYC + 500;
        while (rx_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        got = (rx_q.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tdm_bclk, tdm_fs, tdm_sd, underrun, overrun, pif.in_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_outputs: bclk,fs,sd,un,ov,rdy=%b required 000001",
                     {tdm_bclk, tdm_fs, tdm_sd, underrun, overrun, pif.in_ready});
        end
        repeat (30) @(negedge clk);
        checks++;
        if (rise_cnt !== 0 || tdm_fs !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: bclk rises %0d fs %b, required 0 and 0", rise_cnt, tdm_fs);
        end
    endtask

    task automatic test_basic();
        logic ok, got;
        ser_t r, e;
        do_reset();
        send_frame(ramp_frame(1), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_accept: in_ready never seen, required 1"); end
        checks++;
        if ({tdm_fs, tdm_bclk, pif.in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL basic_after_capture: fs,bclk,rdy=%b required 001", {tdm_fs, tdm_bclk, pif.in_ready});
        end
        @(negedge clk);
        checks++;
        if ({tdm_fs, tdm_sd, tdm_bclk} !== 3'b100) begin
            errors++;
            $display("FAIL basic_start: fs,sd,bclk=%b required 100", {tdm_fs, tdm_sd, tdm_bclk});
        end
        repeat (CLK_DIV - 1) @(negedge clk);
        checks++;
        if (tdm_bclk !== 1'b0) begin errors++; $display("FAIL basic_bclk_early: bclk %b required 0", tdm_bclk); end
        @(negedge clk);
        checks++;
        if (tdm_bclk !== 1'b1) begin errors++; $display("FAIL basic_bclk_rise: bclk %b required 1", tdm_bclk); end
        wait_rx(1, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL basic_rx_timeout: frames %0d required 1", rx_q.size());
        end else begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin errors++; $display("FAIL basic_frame: got %h required %h", r, e); end
            checks++;
            if (r[NB-1 -: SLOT_BITS] !== 24'h000020 || r[SLOT_BITS-1:0] !== 24'h000200) begin
                errors++;
                $display("FAIL basic_slots: slot0 %h slot15 %h required 000020 000200",
                         r[NB-1 -: SLOT_BITS], r[SLOT_BITS-1:0]);
            end
        end
        checks++;
        if (rise_last - rise_prev !== 2 * CLK_DIV) begin
            errors++;
            $display("FAIL basic_bclk_period: %0d clk required %0d", rise_last - rise_prev, 2 * CLK_DIV);
        end
    endtask

    task automatic test_sign();
        logic ok, got;
        ser_t r, e;
        pcm_t p;
        do_reset();
        p = rand_frame();
        p[DATA_W-1:0] = 19'h40000;
        send_frame(p, ok);
        wait_rx(1, got);
        checks++;
        if (!ok || !got) begin
            errors++;
            $display("FAIL sign_timeout: accepted %b frames %0d required 1 1", ok, rx_q.size());
        end else begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r[NB-1 -: SLOT_BITS] !== 24'h800000) begin
                errors++;
                $display("FAIL sign_slot0: got %h required 800000", r[NB-1 -: SLOT_BITS]);
            end
            checks++;
            if (r !== e) begin errors++; $display("FAIL sign_frame: got %h required %h", r, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic ok, got;
        ser_t r, e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_frame(rand_frame(), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_accept: frame %0d not accepted, required accepted", i); end
        end
        wait_rx(3, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_rx_timeout: frames %0d required 3", rx_q.size());
        end else begin
            checks++;
            if (under_cnt !== 0) begin errors++; $display("FAIL b2b_underrun: %0d pulses required 0", under_cnt); end
            for (int i = 0; i < 3; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r !== e) begin errors++; $display("FAIL b2b_frame%0d: got %h required %h", i, r, e); end
            end
            checks++;
            if (fs_q.size() < 3 || fs_q[1] - fs_q[0] !== FRAME_CYC || fs_q[2] - fs_q[1] !== FRAME_CYC) begin
                errors++;
                $display("FAIL b2b_fs_spacing: %0d fs pulses, spacing %0d %0d required %0d",
                         fs_q.size(), fs_q.size() > 1 ? fs_q[1] - fs_q[0] : -1,
                         fs_q.size() > 2 ? fs_q[2] - fs_q[1] : -1, FRAME_CYC);
            end
        end
    endtask

    task automatic test_underrun();
        logic ok, got;
        ser_t r, e;
        do_reset();
        send_frame(rand_frame(), ok);
        exp_q.push_back('0);
        exp_q.push_back('0);
        wait_rx(3, got);
        checks++;
        if (!ok || !got) begin
            errors++;
            $display("FAIL underrun_timeout: accepted %b frames %0d required 1 3", ok, rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r !== e) begin errors++; $display("FAIL underrun_frame%0d: got %h required %h", i, r, e); end
            end
            checks++;
            if (under_cnt !== 2) begin errors++; $display("FAIL underrun_count: %0d required 2", under_cnt); end
            checks++;
            if (fs_q.size() < 2 || under_first !== fs_q[1]) begin
                errors++;
                $display("FAIL underrun_time: pulse at %0d required %0d", under_first,
                         fs_q.size() > 1 ? fs_q[1] : -1);
            end
        end
    endtask

    task automatic test_overrun();
        logic ok, got;
        int n = 0;
        ser_t r, e;
        do_reset();
        send_frame(ramp_frame(100), ok);
        while (fs_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
        send_frame(ramp_frame(200), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL overrun_accept_b: not accepted, required accepted"); end
        pif.pcm_flat = ramp_frame(300);
        pif.in_valid = 1'b1;
        checks++;
        if (pif.in_ready !== 1'b0) begin errors++; $display("FAIL overrun_ready: in_ready %b required 0", pif.in_ready); end
        @(negedge clk);
        pif.in_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: overrun %b required 1", overrun); end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_width: overrun %b required 0", overrun); end
        wait_rx(2, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL overrun_rx_timeout: frames %0d required 2", rx_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r !== e) begin errors++; $display("FAIL overrun_frame%0d: got %h required %h", i, r, e); end
            end
            checks++;
            if (over_cnt !== 1) begin errors++; $display("FAIL overrun_count: %0d required 1", over_cnt); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic ok, got;
        int n = 0;
        ser_t r, e;
        pcm_t c;
        do_reset();
        send_frame(rand_frame(), ok);
        send_frame(rand_frame(), ok);
        while (pos < 100 && n < 200 * CLK_DIV) begin @(negedge clk); n++; end
        checks++;
        if (pos < 100 || pif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_setup: bit %0d in_ready %b required >=100 and 0", pos, pif.in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tdm_bclk, tdm_fs, tdm_sd, underrun, overrun, pif.in_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL midrst_outputs: bclk,fs,sd,un,ov,rdy=%b required 000001",
                     {tdm_bclk, tdm_fs, tdm_sd, underrun, overrun, pif.in_ready});
        end
        repeat (2) @(negedge clk);
        exp_q.delete(); rx_q.delete(); fs_q.delete();
        rise_cnt = 0;
        #3 rst = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (rise_cnt !== 0 || fs_q.size() !== 0) begin
            errors++;
            $display("FAIL midrst_idle: bclk rises %0d fs pulses %0d required 0 0", rise_cnt, fs_q.size());
        end
        c = rand_frame();
        send_frame(c, ok);
        wait_rx(1, got);
        checks++;
        if (!ok || !got) begin
            errors++;
            $display("FAIL midrst_restart: accepted %b frames %0d required 1 1", ok, rx_q.size());
        end else begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin errors++; $display("FAIL midrst_frame: got %h required %h", r, e); end
        end
    endtask

    initial begin
        pif.in_valid = 1'b0;
        pif.pcm_flat = '0;
        test_reset();
        test_basic();
        test_sign();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
